// File: rtl/register_bank_mp.sv
// NREAD-port register file: hardwired-zero r0, post-reset clear sequencer, optional REGFILE_BYPASS_EN forwarding.
// Reads are combinational, writes land on the edge; there is no backpressure and writes issued while ready=0 are dropped.
module register_bank_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         ain,
  input  logic [XLEN-1:0]       din,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic                  ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] regs_q [NREGS];

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  // The clear sequencer and the external write port share one array write port.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    wr_en     = 1'b0;
    wr_addr   = ain;
    wr_data   = din;
    if (reset) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          wr_en     = 1'b1;
          wr_addr   = clr_idx_q;
          wr_data   = '0;
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == AW'(NREGS - 1)) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
        IDLE: begin
          wr_en = we && (ain != '0);
        end
        default: begin
          state_d   = CLEAR;
          clr_idx_d = '0;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Array contents survive the reset edge; only the sequencer zeroes them.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_val;

    assign rd_addr = raddr[k*AW +: AW];

    always_comb begin
      rd_val = regs_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
      if (we && (ain == rd_addr)) begin
        rd_val = din;
      end
`endif
      // r0 and the not-yet-cleared array always read as zero.
      if (!ready_q || (rd_addr == '0)) begin
        rd_val = '0;
      end
    end

    assign rdata[k*XLEN +: XLEN] = rd_val;
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_register_bank_mp.sv
// Randomized bench for register_bank_mp: a 32x32 2-port instance and a 16x16 4-port instance against array models.
`timescale 1ns/1ps
module tb_register_bank_mp;

  localparam int A_NREGS = 32;
  localparam int B_NREGS = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        a_reset, a_we, a_ready;
  logic [4:0]  a_ain;
  logic [31:0] a_din;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;

  logic        b_reset, b_we, b_ready;
  logic [3:0]  b_ain;
  logic [15:0] b_din;
  logic [15:0] b_raddr;
  logic [63:0] b_rdata;

  register_bank_mp #(.XLEN(32), .NREGS(32), .NREAD(2)) dut_a (
    .clock(clock), .reset(a_reset), .we(a_we), .ain(a_ain), .din(a_din),
    .raddr(a_raddr), .rdata(a_rdata), .ready(a_ready)
  );

  register_bank_mp #(.XLEN(16), .NREGS(16), .NREAD(4)) dut_b (
    .clock(clock), .reset(b_reset), .we(b_we), .ain(b_ain), .din(b_din),
    .raddr(b_raddr), .rdata(b_rdata), .ready(b_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference models: a plain array plus "ready after NREGS clean edges".
  logic [31:0] a_mem [A_NREGS];
  bit          a_rdy_m;
  int          a_cnt;
  logic [15:0] b_mem [B_NREGS];
  bit          b_rdy_m;
  int          b_cnt;

  function automatic logic [31:0] a_exp(input logic [4:0] ra);
    if (!a_rdy_m || ra == 5'd0) return 32'h0;
    if (BYPASS && a_we && a_ain == ra) return a_din;
    return a_mem[ra];
  endfunction

  function automatic logic [15:0] b_exp(input logic [3:0] ra);
    if (!b_rdy_m || ra == 4'd0) return 16'h0;
    if (BYPASS && b_we && b_ain == ra) return b_din;
    return b_mem[ra];
  endfunction

  task automatic a_edge();
    @(posedge clock);
    if (a_reset) begin
      a_rdy_m = 1'b0;
      a_cnt   = 0;
    end else if (!a_rdy_m) begin
      a_cnt++;
      if (a_cnt == A_NREGS) begin
        a_rdy_m = 1'b1;
        foreach (a_mem[i]) a_mem[i] = 32'h0;
      end
    end else if (a_we && a_ain != 5'd0) begin
      a_mem[a_ain] = a_din;
    end
    #1;
  endtask

  task automatic b_edge();
    @(posedge clock);
    if (b_reset) begin
      b_rdy_m = 1'b0;
      b_cnt   = 0;
    end else if (!b_rdy_m) begin
      b_cnt++;
      if (b_cnt == B_NREGS) begin
        b_rdy_m = 1'b1;
        foreach (b_mem[i]) b_mem[i] = 16'h0;
      end
    end else if (b_we && b_ain != 4'd0) begin
      b_mem[b_ain] = b_din;
    end
    #1;
  endtask

  task automatic a_cycle(input logic rst, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1);
    a_reset = rst;
    a_we    = w;
    a_ain   = wa;
    a_din   = wd;
    a_raddr = {r1, r0};
    @(negedge clock);
    check("a_ready", {31'h0, a_ready}, {31'h0, a_rdy_m});
    check("a_rd0", a_rdata[31:0], a_exp(r0));
    check("a_rd1", a_rdata[63:32], a_exp(r1));
    a_edge();
  endtask

  task automatic b_cycle(input logic rst, input logic w, input logic [3:0] wa,
                         input logic [15:0] wd, input logic [15:0] ra);
    b_reset = rst;
    b_we    = w;
    b_ain   = wa;
    b_din   = wd;
    b_raddr = ra;
    @(negedge clock);
    check("b_ready", {31'h0, b_ready}, {31'h0, b_rdy_m});
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b_rd%0d", k), {16'h0, b_rdata[k*16 +: 16]}, {16'h0, b_exp(ra[k*4 +: 4])});
    end
    b_edge();
  endtask

  initial begin
    int first_rdy;
    logic [4:0]  wa, r0, r1;
    logic [3:0]  bwa;
    logic [15:0] bra;

    a_reset = 1'b1; a_we = 1'b0; a_ain = '0; a_din = '0; a_raddr = '0;
    b_reset = 1'b1; b_we = 1'b0; b_ain = '0; b_din = '0; b_raddr = '0;
    a_rdy_m = 1'b0; a_cnt = 0;
    b_rdy_m = 1'b0; b_cnt = 0;
    @(posedge clock);
    #1;

    // Reset state and clear timing; ready must rise on edge NREGS.
    first_rdy = 0;
    for (int i = 1; i <= A_NREGS; i++) begin
      a_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'($urandom), 5'($urandom));
      if (a_ready && first_rdy == 0) first_rdy = i;
    end
    check("ready_edge", 32'(first_rdy), 32'(A_NREGS));
    for (int i = 0; i < A_NREGS / 2; i++) begin
      a_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(2 * i), 5'(2 * i + 1));
    end

    // Write then read the same register on both ports.
    a_cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    a_we = 1'b0; a_raddr = {5'd5, 5'd5}; #1;
    check("r5_p0", a_rdata[31:0], 32'hDEADBEEF);
    check("r5_p1", a_rdata[63:32], 32'hDEADBEEF);

    // Writes to r0 are discarded.
    a_cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
    a_we = 1'b0; a_raddr = {5'd0, 5'd0}; #1;
    check("r0_p0", a_rdata[31:0], 32'h0);
    check("r0_p1", a_rdata[63:32], 32'h0);

    // Same-cycle read of a register being written.
    a_reset = 1'b0; a_we = 1'b1; a_ain = 5'd7; a_din = 32'h1234; a_raddr = {5'd5, 5'd7}; #1;
    check("r7_same", a_rdata[31:0], BYPASS ? 32'h1234 : 32'h0);
    a_edge();
    a_we = 1'b0; #1;
    check("r7_next", a_rdata[31:0], 32'h1234);

    // Reset mid-clear at clr_idx=10 restarts the sequence; writes during clear are lost.
    a_cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    for (int i = 0; i < 10; i++) a_cycle(1'b0, 1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd5);
    a_cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
    first_rdy = 0;
    for (int i = 1; i <= A_NREGS + 2; i++) begin
      a_cycle(1'b0, (i == 20), 5'd3, 32'h0BAD0BAD, 5'd3, 5'd7);
      if (a_ready && first_rdy == 0) first_rdy = i;
    end
    check("ready_edge2", 32'(first_rdy), 32'(A_NREGS));
    a_raddr = {5'd5, 5'd3}; a_we = 1'b0; #1;
    check("lost_wr_r3", a_rdata[31:0], 32'h0);
    check("cleared_r5", a_rdata[63:32], 32'h0);

    // Random traffic with bias toward read-of-written-address.
    for (int i = 0; i < 400; i++) begin
      wa = 5'($urandom);
      r0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      a_cycle(($urandom_range(0, 199) == 0), 1'($urandom), wa, $urandom, r0, r1);
    end

    // 4-port 16x16 instance: clear, fill, distinct-address reads, random run.
    for (int i = 0; i < B_NREGS; i++) b_cycle(1'b0, 1'b0, 4'd0, 16'h0, 16'($urandom));
    check("b_ready_up", {31'h0, b_ready}, 32'h1);
    for (int i = 1; i < B_NREGS; i++) b_cycle(1'b0, 1'b1, 4'(i), 16'(i * 16'h111), 16'h0);
    b_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_raddr = {4'(4 * i + 3), 4'(4 * i + 2), 4'(4 * i + 1), 4'(4 * i)}; #1;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("b_fill_r%0d", 4 * i + k), {16'h0, b_rdata[k*16 +: 16]}, 32'((4 * i + k) * 16'h111));
      end
    end
    for (int i = 0; i < 1000; i++) begin
      bwa = 4'($urandom);
      bra = 16'($urandom);
      if ($urandom_range(0, 2) == 0) bra[4 * $urandom_range(0, 3) +: 4] = bwa;
      b_cycle(($urandom_range(0, 249) == 0), 1'($urandom), bwa, 16'($urandom), bra);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
